// File: rtl/rpn_seq_pkg.sv
// Shared opcode and state encodings for the RPN token sequencer.
package rpn_seq_pkg;

  localparam int unsigned OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_PUSH = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_POP  = 3'b111;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_FINAL   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

endpackage

// File: rtl/rpn_depth_ctr.sv
// Saturating ALU stack depth tracker with full and fewer-than-two flags.
module rpn_depth_ctr #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [DW-1:0] depth,
  output logic          full_c,
  output logic          lt2_c
);

  assign full_c = (depth == DW'(STACK_DEPTH));
  assign lt2_c  = (depth < DW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
    end else if (inc && !dec && !full_c) begin
      depth <= depth + DW'(1);
    end else if (dec && !inc && (depth != '0)) begin
      depth <= depth - DW'(1);
    end
  end

endmodule

// File: rtl/rpn_token_sequencer.sv
// Converts an RPN token stream into ALU opcodes and returns the expression result.
// Optional error counter enabled by defining RPN_SEQ_ERRCNT_EN.
module rpn_token_sequencer
  import rpn_seq_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                tok_valid,
  output logic                tok_ready,
  input  logic                tok_is_op,
  input  logic                tok_op,
  input  logic [N-1:0]        tok_data,
  input  logic                tok_last,
  output logic [OPCODE_W-1:0] alu_opcode,
  output logic [N-1:0]        alu_data,
  input  logic [N-1:0]        alu_out,
  input  logic                alu_ovf,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [N-1:0]        res_data,
  output logic                res_err,
  output logic                res_ovf,
  output logic [15:0]         err_count
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

  state_t                state, state_nx;
  logic [OPCODE_W-1:0]   opcode_nx;
  logic [N-1:0]          data_nx;
  logic                  tok_ready_nx;
  logic                  res_valid_nx, res_err_nx, res_ovf_nx;
  logic [N-1:0]          res_data_nx;
  logic                  err_flag, err_flag_nx;
  logic                  arith_d;
  logic                  depth_inc, depth_dec;
  logic [DW-1:0]         depth;
  logic                  full_c, lt2_c;
  logic                  accept_c;
  logic                  tok_err_c;
  logic                  handshake_c;

  rpn_depth_ctr #(
    .STACK_DEPTH (STACK_DEPTH),
    .DW          (DW)
  ) u_depth (
    .clk    (CLK),
    .rst_n  (RST_N),
    .inc    (depth_inc),
    .dec    (depth_dec),
    .depth  (depth),
    .full_c (full_c),
    .lt2_c  (lt2_c)
  );

  assign accept_c    = tok_valid && tok_ready;
  assign handshake_c = res_valid && res_ready;

  // Next-state and next-output decode
  always_comb begin
    state_nx     = state;
    opcode_nx    = OP_NOP;
    data_nx      = '0;
    res_valid_nx = res_valid;
    res_data_nx  = res_data;
    res_err_nx   = res_err;
    res_ovf_nx   = res_ovf | (arith_d & alu_ovf);
    err_flag_nx  = err_flag;
    depth_inc    = 1'b0;
    depth_dec    = 1'b0;
    tok_err_c    = 1'b0;

    case (state)
      ST_RUN: begin
        if (accept_c) begin
          if (tok_is_op) begin
            if (lt2_c) begin
              tok_err_c = 1'b1;
            end else begin
              opcode_nx = tok_op ? OP_MUL : OP_ADD;
              depth_dec = 1'b1;
            end
          end else begin
            if (full_c) begin
              tok_err_c = 1'b1;
            end else begin
              opcode_nx = OP_PUSH;
              data_nx   = tok_data;
              depth_inc = 1'b1;
            end
          end
          if (tok_err_c) begin
            err_flag_nx = 1'b1;
            state_nx    = tok_last ? ST_FLUSH : ST_DRAIN;
          end else if (tok_last) begin
            state_nx = ST_FINAL;
          end
        end
      end

      ST_DRAIN: begin
        if (accept_c && tok_last) begin
          state_nx = ST_FLUSH;
        end
      end

      ST_FINAL: begin
        if (depth != DW'(1)) begin
          err_flag_nx = 1'b1;
          state_nx    = ST_FLUSH;
        end else begin
          opcode_nx = OP_POP;
          depth_dec = 1'b1;
          state_nx  = ST_CAPTURE;
        end
      end

      // ALU output is only valid once the POP has executed on the previous edge
      ST_CAPTURE: begin
        if (alu_opcode != OP_POP) begin
          res_data_nx  = alu_out;
          res_err_nx   = 1'b0;
          res_valid_nx = 1'b1;
          state_nx     = ST_HOLD;
        end
      end

      ST_FLUSH: begin
        if (depth != '0) begin
          opcode_nx = OP_POP;
          depth_dec = 1'b1;
        end else begin
          res_data_nx  = '0;
          res_err_nx   = 1'b1;
          res_valid_nx = 1'b1;
          state_nx     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (handshake_c) begin
          res_valid_nx = 1'b0;
          res_data_nx  = '0;
          res_err_nx   = 1'b0;
          res_ovf_nx   = 1'b0;
          err_flag_nx  = 1'b0;
          state_nx     = ST_RUN;
        end
      end

      default: begin
        state_nx = ST_RUN;
      end
    endcase

    tok_ready_nx = (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_RUN;
      alu_opcode <= OP_NOP;
      alu_data   <= '0;
      tok_ready  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_err    <= 1'b0;
      res_ovf    <= 1'b0;
      err_flag   <= 1'b0;
      arith_d    <= 1'b0;
    end else begin
      state      <= state_nx;
      alu_opcode <= opcode_nx;
      alu_data   <= data_nx;
      tok_ready  <= tok_ready_nx;
      res_valid  <= res_valid_nx;
      res_data   <= res_data_nx;
      res_err    <= res_err_nx;
      res_ovf    <= res_ovf_nx;
      err_flag   <= err_flag_nx;
      arith_d    <= (alu_opcode == OP_ADD) || (alu_opcode == OP_MUL);
    end
  end

`ifdef RPN_SEQ_ERRCNT_EN
  // Counts delivered error results, saturating
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_count <= '0;
    end else if (handshake_c && res_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rpn_token_sequencer.sv
// Directed bench for rpn_token_sequencer with a small stack-ALU model attached.
module tb_rpn_token_sequencer;

  localparam int unsigned N = 8;
  localparam logic [2:0] NOP = 3'b000, ADD = 3'b100, MUL = 3'b101, PUSH = 3'b110, POP = 3'b111;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic         tok_is_op = 1'b0;
  logic         tok_op = 1'b0;
  logic [N-1:0] tok_data = '0;
  logic         tok_last = 1'b0;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_data;
  logic [N-1:0] alu_out;
  logic         alu_ovf;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [N-1:0] res_data;
  logic         res_err;
  logic         res_ovf;
  logic [15:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [2:0] ops [$];
  bit         rec = 1'b0;

  always #5 CLK = ~CLK;

  rpn_token_sequencer #(.N(8), .STACK_DEPTH(8)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .tok_is_op  (tok_is_op),
    .tok_op     (tok_op),
    .tok_data   (tok_data),
    .tok_last   (tok_last),
    .alu_opcode (alu_opcode),
    .alu_data   (alu_data),
    .alu_out    (alu_out),
    .alu_ovf    (alu_ovf),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .res_ovf    (res_ovf),
    .err_count  (err_count)
  );

  // Stack ALU model: signed 8-bit add/mul with overflow, registered POP output
  logic [N-1:0]       stk [0:15];
  logic [4:0]         sp;
  logic [N-1:0]       op_a, op_b;
  logic signed [15:0] wide;

  always_comb begin
    op_a = (sp >= 5'd2) ? stk[4'(sp - 5'd2)] : '0;
    op_b = (sp >= 5'd1) ? stk[4'(sp - 5'd1)] : '0;
    if (alu_opcode == MUL)
      wide = $signed({{8{op_a[7]}}, op_a}) * $signed({{8{op_b[7]}}, op_b});
    else
      wide = $signed({{8{op_a[7]}}, op_a}) + $signed({{8{op_b[7]}}, op_b});
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sp      <= '0;
      alu_out <= '0;
      alu_ovf <= 1'b0;
    end else begin
      case (alu_opcode)
        PUSH: if (sp < 5'd16) begin
          stk[4'(sp)] <= alu_data;
          sp <= sp + 5'd1;
        end
        ADD, MUL: if (sp >= 5'd2) begin
          stk[4'(sp - 5'd2)] <= wide[7:0];
          alu_ovf <= (wide > 16'sd127) || (wide < -16'sd128);
          sp <= sp - 5'd1;
        end
        POP: if (sp >= 5'd1) begin
          alu_out <= stk[4'(sp - 5'd1)];
          sp <= sp - 5'd1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge CLK) if (rec) ops.push_back(alu_opcode);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic send(input bit is_op, input bit op, input logic [7:0] d, input bit last);
    int n = 0;
    @(negedge CLK);
    while (!tok_ready && n < 50) begin @(negedge CLK); n++; end
    if (!tok_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: tok_ready=%0b required 1", tok_ready);
    end
    tok_valid = 1'b1; tok_is_op = is_op; tok_op = op; tok_data = d; tok_last = last;
    @(posedge CLK);
  endtask

  task automatic idle();
    @(negedge CLK);
    tok_valid = 1'b0; tok_last = 1'b0; tok_is_op = 1'b0; tok_data = '0;
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 100) begin @(negedge CLK); n++; end
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL res_timeout: res_valid=%0b required 1", res_valid);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #12;
    checks++;
    if ({alu_opcode, alu_data, tok_ready, res_valid, res_data, res_err, res_ovf, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: op=%b data=%h rdy=%b rv=%b rd=%h re=%b ro=%b ec=%h required all 0",
               alu_opcode, alu_data, tok_ready, res_valid, res_data, res_err, res_ovf, err_count);
    end
    @(posedge CLK); #1 RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (tok_ready !== 1'b0) begin errors++; $display("FAIL reset_first_cycle_ready: %b required 0", tok_ready); end
    @(negedge CLK);
    checks++;
    if (tok_ready !== 1'b1) begin errors++; $display("FAIL reset_second_cycle_ready: %b required 1", tok_ready); end
  endtask

  task automatic test_basic();
    logic [2:0] exp_ops [6];
    int first;
    exp_ops[0] = PUSH; exp_ops[1] = PUSH; exp_ops[2] = ADD;
    exp_ops[3] = PUSH; exp_ops[4] = MUL;  exp_ops[5] = POP;
    ops.delete(); rec = 1'b1;
    send(0, 0, 8'd3, 0);
    send(0, 0, 8'd4, 0);
    send(1, 0, 8'd0, 0);
    send(0, 0, 8'd5, 0);
    send(1, 1, 8'd0, 1);
    idle();
    wait_res();
    rec = 1'b0;
    checks++;
    if (res_data !== 8'd35 || res_err !== 1'b0 || res_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: data=%0d err=%b ovf=%b required 35 0 0", res_data, res_err, res_ovf);
    end
    first = -1;
    foreach (ops[i]) if (first < 0 && ops[i] != NOP) first = i;
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (first < 0 || first + j >= ops.size()) begin
        errors++; $display("FAIL basic_opseq[%0d]: missing required %b", j, exp_ops[j]);
      end else if (ops[first + j] !== exp_ops[j]) begin
        errors++; $display("FAIL basic_opseq[%0d]: %b required %b", j, ops[first + j], exp_ops[j]);
      end
    end
    @(negedge CLK);
    checks++;
    if (res_valid !== 1'b0 || tok_ready !== 1'b1) begin
      errors++; $display("FAIL basic_after_handshake: rv=%b rdy=%b required 0 1", res_valid, tok_ready);
    end
  endtask

  task automatic test_overflow();
    send(0, 0, 8'd100, 0);
    send(0, 0, 8'd100, 0);
    send(1, 1, 8'd0, 1);
    idle();
    wait_res();
    checks++;
    if (res_data !== 8'd16 || res_err !== 1'b0 || res_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_result: data=%0d err=%b ovf=%b required 16 0 1", res_data, res_err, res_ovf);
    end
    @(negedge CLK);
  endtask

  task automatic test_underflow();
    int pops = 0, ariths = 0;
    ops.delete(); rec = 1'b1;
    send(0, 0, 8'd3, 0);
    send(1, 0, 8'd0, 1);
    idle();
    wait_res();
    rec = 1'b0;
    foreach (ops[i]) begin
      if (ops[i] == POP) pops++;
      if (ops[i] == ADD || ops[i] == MUL) ariths++;
    end
    checks++;
    if (res_err !== 1'b1 || res_data !== 8'd0) begin
      errors++; $display("FAIL underflow_result: err=%b data=%0d required 1 0", res_err, res_data);
    end
    checks++;
    if (pops != 1 || ariths != 0) begin
      errors++; $display("FAIL underflow_ops: pops=%0d arith=%0d required 1 0", pops, ariths);
    end
    @(negedge CLK);
    send(0, 0, 8'd2, 0);
    send(0, 0, 8'd2, 0);
    send(1, 0, 8'd0, 1);
    idle();
    wait_res();
    checks++;
    if (res_data !== 8'd4 || res_err !== 1'b0 || res_ovf !== 1'b0) begin
      errors++;
      $display("FAIL underflow_recover: data=%0d err=%b ovf=%b required 4 0 0", res_data, res_err, res_ovf);
    end
    @(negedge CLK);
  endtask

  task automatic test_stack_full();
    int pops = 0, pushes = 0;
    logic [15:0] exp_cnt;
`ifdef RPN_SEQ_ERRCNT_EN
    exp_cnt = 16'd2;
`else
    exp_cnt = 16'd0;
`endif
    ops.delete(); rec = 1'b1;
    for (int k = 1; k <= 9; k++) send(0, 0, 8'(k), k == 9);
    idle();
    wait_res();
    rec = 1'b0;
    foreach (ops[i]) begin
      if (ops[i] == POP) pops++;
      if (ops[i] == PUSH) pushes++;
    end
    checks++;
    if (res_err !== 1'b1 || res_data !== 8'd0) begin
      errors++; $display("FAIL full_result: err=%b data=%0d required 1 0", res_err, res_data);
    end
    checks++;
    if (pushes != 8 || pops != 8) begin
      errors++; $display("FAIL full_ops: pushes=%0d pops=%0d required 8 8", pushes, pops);
    end
    @(negedge CLK);
    checks++;
    if (err_count !== exp_cnt) begin
      errors++; $display("FAIL full_err_count: %0d required %0d", err_count, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    send(0, 0, 8'd7, 0);
    send(0, 0, 8'hFE, 0);
    send(1, 0, 8'd0, 1);
    idle();
    wait_res();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 8'd5 || res_err !== 1'b0 || tok_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: rv=%b data=%0d err=%b rdy=%b required 1 5 0 0",
                 c, res_valid, res_data, res_err, tok_ready);
      end
      @(negedge CLK);
    end
    res_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (res_valid !== 1'b0 || tok_ready !== 1'b1 || res_data !== 8'd0) begin
      errors++;
      $display("FAIL hold_release: rv=%b rdy=%b data=%0d required 0 1 0", res_valid, tok_ready, res_data);
    end
  endtask

  task automatic test_reset_in_drain();
    send(0, 0, 8'd5, 0);
    send(1, 0, 8'd0, 0);
    send(0, 0, 8'd1, 0);
    idle();
    checks++;
    if (tok_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: %b required 1", tok_ready); end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({alu_opcode, alu_data, tok_ready, res_valid, res_data, res_err, res_ovf, err_count} !== '0) begin
      errors++;
      $display("FAIL drain_reset_outputs: op=%b data=%h rdy=%b rv=%b rd=%h re=%b ro=%b ec=%h required all 0",
               alu_opcode, alu_data, tok_ready, res_valid, res_data, res_err, res_ovf, err_count);
    end
    @(posedge CLK); #1 RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (tok_ready !== 1'b0) begin errors++; $display("FAIL drain_release_first: %b required 0", tok_ready); end
    @(negedge CLK);
    checks++;
    if (tok_ready !== 1'b1) begin errors++; $display("FAIL drain_release_second: %b required 1", tok_ready); end
    send(0, 0, 8'd2, 0);
    send(0, 0, 8'd3, 0);
    send(1, 1, 8'd0, 1);
    idle();
    wait_res();
    checks++;
    if (res_data !== 8'd6 || res_err !== 1'b0) begin
      errors++; $display("FAIL drain_recover: data=%0d err=%b required 6 0", res_data, res_err);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_stack_full();
    test_backpressure();
    test_reset_in_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
